iddrx2_deser: RTL and testbench

- Behavioural simulation model of a 1:4 gearing DDR input deserializer; the receive-side counterpart of the 4:1 DDR output serializer models.
- Samples serial pin data on both edges of the fast edge clock ECLK and presents 4-bit parallel words on an internally divided slow clock SCLK (ECLK/2), which is also output.
- Supports word-alignment bit slip via ALIGNWD.
- Sits in the sim/ primitive library next to the other DDR I/O models.

---
 rtl/iddrx2_deser_pkg.sv | 24 ++
 rtl/gsr_pur_assign.sv | 12 +
 rtl/iddrx2_slip_ctrl.sv | 40 ++++
 rtl/iddrx2_deser.sv | 101 ++++++++++
 tb/tb_iddrx2_deser.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/iddrx2_deser_pkg.sv
// iddrx2_deser shared definitions: history depth, slip-offset width and the
// word-select helper used at each SCLK rising edge.
package iddrx2_deser_pkg;

    // Seven bits cover the oldest bit needed by the largest slip offset (3).
    localparam int HIST_W = 7;
    localparam int OFF_W  = 2;

    // win[0] is the newest captured bit b(k-1), win[i] is b(k-1-i).
    // Returns {Q3,Q2,Q1,Q0} = {b(k-1-off) .. b(k-4-off)}.
    function automatic logic [3:0] pick_word(input logic [HIST_W-1:0] win,
                                             input logic [OFF_W-1:0]  off);
        logic [3:0] w;
        w = '0;
        case (off)
            2'd0: w = {win[0], win[1], win[2], win[3]};
            2'd1: w = {win[1], win[2], win[3], win[4]};
            2'd2: w = {win[2], win[3], win[4], win[5]};
            2'd3: w = {win[3], win[4], win[5], win[6]};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/gsr_pur_assign.sv
// Global set/reset and power-up reset sources for the DDR I/O models.
// Both are inactive (1) in the default build; a board-level model can
// replace this module to exercise the global reset paths.
module gsr_pur_assign (
    output logic gsr,
    output logic pur
);

    assign gsr = 1'b1;
    assign pur = 1'b1;

endmodule

// File: rtl/iddrx2_slip_ctrl.sv
// ALIGNWD rising-edge detect, lockout timer and word-slip offset register.
// A slip is accepted only on a rising edge while the lockout timer is idle;
// the timer then ignores further requests for LOCKOUT ECLK posedges.
module iddrx2_slip_ctrl
    import iddrx2_deser_pkg::*;
#(
    parameter int LOCKOUT = 4
) (
    input  logic             eclk,
    input  logic             rst_internal,
    input  logic             alignwd,
    output logic [OFF_W-1:0] off
);

    localparam logic [2:0] LOCK_LOAD = 3'(LOCKOUT);

    logic       align_prev;
    logic [2:0] lock_cnt;
    logic       accept;

    assign accept = alignwd && !align_prev && (lock_cnt == 3'd0);

    // Edge history, offset advance on accepted slips, lockout down-count.
    always_ff @(posedge eclk or posedge rst_internal) begin
        if (rst_internal) begin
            align_prev <= 1'b0;
            lock_cnt   <= 3'd0;
            off        <= '0;
        end else begin
            align_prev <= alignwd;
            if (accept) begin
                off      <= off + 1'b1;
                lock_cnt <= LOCK_LOAD;
            end else if (lock_cnt != 3'd0) begin
                lock_cnt <= lock_cnt - 3'd1;
            end
        end
    end

endmodule

// File: rtl/iddrx2_deser.sv
// 1:4 DDR input deserializer. D is captured on both ECLK edges, SCLK = ECLK/2
// and a 4-bit word is presented at every SCLK rising edge.
// Optional macro IDDRX2_ALIGNWD_EN compiles in ALIGNWD word-slip support;
// without it the slip offset is fixed at 0 and ALIGNWD is ignored.
module iddrx2_deser
    import iddrx2_deser_pkg::*;
#(
    parameter string GSR     = "ENABLED",
    parameter int    LOCKOUT = 4
) (
    input  logic ECLK,
    input  logic RST,
    input  logic D,
    input  logic ALIGNWD,
    output logic SCLK,
    output logic Q0,
    output logic Q1,
    output logic Q2,
    output logic Q3,
    output logic VALID
);

    // Posedges remaining until the first word made only of post-reset bits.
    localparam logic [2:0] WARM_INIT = 3'd4;

    logic              gsr;
    logic              pur;
    logic              rst_internal;
    logic              sclk;
    logic              d_neg;
    logic [HIST_W-2:0] hist_pos;
    logic [HIST_W-1:0] window;
    logic [2:0]        warm_cnt;
    logic [3:0]        q_word;
    logic              valid;
    logic [OFF_W-1:0]  off;

    gsr_pur_assign u_gsr_pur (
        .gsr (gsr),
        .pur (pur)
    );

    assign rst_internal = (GSR == "ENABLED") ? (RST | ~(gsr & pur)) : (RST | ~pur);

`ifdef IDDRX2_ALIGNWD_EN
    iddrx2_slip_ctrl #(
        .LOCKOUT (LOCKOUT)
    ) u_slip_ctrl (
        .eclk         (ECLK),
        .rst_internal (rst_internal),
        .alignwd      (ALIGNWD),
        .off          (off)
    );
`else
    logic unused_alignwd;
    assign unused_alignwd = ALIGNWD;
    assign off = '0;
`endif

    // The negedge bit joins the posedge history as the newest entry, so the
    // full 7-bit history is available at the posedge that closes a word.
    assign window = {hist_pos, d_neg};

    // Falling-edge capture; a negedge before the first posedge after reset
    // precedes bit 0 and must not enter the history.
    always_ff @(negedge ECLK or posedge rst_internal) begin
        if (rst_internal) begin
            d_neg <= 1'b0;
        end else if (warm_cnt != WARM_INIT) begin
            d_neg <= D;
        end
    end

    // Divider, history shift, word load on SCLK rise and VALID warm-up timer.
    always_ff @(posedge ECLK or posedge rst_internal) begin
        if (rst_internal) begin
            sclk     <= 1'b0;
            hist_pos <= '0;
            warm_cnt <= WARM_INIT;
            q_word   <= '0;
            valid    <= 1'b0;
        end else begin
            sclk     <= ~sclk;
            hist_pos <= {hist_pos[HIST_W-4:0], d_neg, D};
            if (warm_cnt != 3'd0) begin
                warm_cnt <= warm_cnt - 3'd1;
            end
            if (!sclk) begin
                q_word <= pick_word(window, off);
                if (warm_cnt == 3'd0) begin
                    valid <= 1'b1;
                end
            end
        end
    end

    assign SCLK              = sclk;
    assign {Q3, Q2, Q1, Q0}  = q_word;
    assign VALID             = valid;

endmodule

// File: tb/tb_iddrx2_deser.sv
// Self-checking bench for iddrx2_deser. Bit stream and ALIGNWD levels are
// planned per run in arrays; expected words are computed from bit indices.
module tb_iddrx2_deser;

    localparam int LOCKOUT = 4;
`ifdef IDDRX2_ALIGNWD_EN
    localparam bit SLIP_EN = 1'b1;
`else
    localparam bit SLIP_EN = 1'b0;
`endif

    logic ECLK    = 1'b0;
    logic RST     = 1'b1;
    logic D       = 1'b0;
    logic ALIGNWD = 1'b0;
    logic SCLK, Q0, Q1, Q2, Q3, VALID;

    int n_cmp = 0;
    int n_mis = 0;

    logic bits [0:1023];
    logic al   [0:511];
    bit   acc  [0:511];

    iddrx2_deser #(
        .GSR     ("ENABLED"),
        .LOCKOUT (LOCKOUT)
    ) dut (
        .ECLK    (ECLK),
        .RST     (RST),
        .D       (D),
        .ALIGNWD (ALIGNWD),
        .SCLK    (SCLK),
        .Q0      (Q0),
        .Q1      (Q1),
        .Q2      (Q2),
        .Q3      (Q3),
        .VALID   (VALID)
    );

    always #5 ECLK = ~ECLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Which posedges accept a slip: rising edge, and more than LOCKOUT
    // posedges since the last accepted one.
    task automatic plan_accepts(input int ncyc);
        int   last;
        logic prev;
        last = -1000;
        for (int n = 0; n < ncyc; n++) begin
            prev = (n == 0) ? 1'b0 : al[n-1];
            acc[n] = SLIP_EN && (al[n] === 1'b1) && (prev !== 1'b1) && (n - last > LOCKOUT);
            if (acc[n]) last = n;
        end
    endtask

    // Word held after posedge n: loaded at the last boundary m <= n from
    // bits k-4-off .. k-1-off, k = 2m, off = slips accepted before m.
    function automatic logic [3:0] exp_word(input int n);
        int m, k, off, idx;
        logic [3:0] w;
        m   = n - (n % 2);
        k   = 2 * m;
        off = 0;
        for (int j = 0; j < m; j++) if (acc[j]) off++;
        off = off % 4;
        for (int i = 0; i < 4; i++) begin
            idx  = k - 4 - off + i;
            w[i] = (idx < 0) ? 1'b0 : bits[idx];
        end
        return w;
    endfunction

    task automatic fill_pattern(input int ncyc);
        for (int i = 0; i < 2 * ncyc + 2; i++) bits[i] = (i % 4 == 0);
        for (int n = 0; n < ncyc; n++) al[n] = 1'b0;
    endtask

    task automatic fill_random(input int ncyc);
        for (int i = 0; i < 2 * ncyc + 2; i++) bits[i] = $urandom_range(1, 0) == 1;
        for (int n = 0; n < ncyc; n++) al[n] = ($urandom_range(4, 0) == 0);
    endtask

    // Hold reset with the pins active, then release just after a posedge so
    // that a falling edge carrying D=1 precedes bit 0.
    task automatic do_reset(input string tag);
        RST = 1'b1;
        ALIGNWD = 1'b0;
        repeat (3) begin
            D = ~D;
            @(posedge ECLK); #1;
            chk({tag, "_rst_sclk"}, SCLK, 8'h00);
            chk({tag, "_rst_q"}, {Q3, Q2, Q1, Q0}, 8'h00);
            chk({tag, "_rst_valid"}, VALID, 8'h00);
        end
        RST = 1'b0;
        D   = 1'b1;
        @(negedge ECLK); #1;
    endtask

    task automatic run(input int ncyc, input int rst_at, input string tag);
        plan_accepts(ncyc);
        for (int n = 0; n < ncyc; n++) begin
            D       = bits[2*n];
            ALIGNWD = al[n];
            @(posedge ECLK); #1;
            chk({tag, "_q"}, {Q3, Q2, Q1, Q0}, exp_word(n));
            chk({tag, "_sclk"}, SCLK, (n % 2 == 0));
            chk({tag, "_valid"}, VALID, (n >= 4));
            D = bits[2*n+1];
            if (n == rst_at) begin
                #1 RST = 1'b1;
                #1;
                chk({tag, "_midrst_q"}, {Q3, Q2, Q1, Q0}, 8'h00);
                chk({tag, "_midrst_sclk"}, SCLK, 8'h00);
                chk({tag, "_midrst_valid"}, VALID, 8'h00);
                return;
            end
            @(negedge ECLK); #1;
        end
    endtask

    initial begin
        // Pattern 1000, pulses at n=5 (accepted) and n=7 (locked out).
        do_reset("a");
        fill_pattern(20);
        al[5] = 1'b1;
        al[7] = 1'b1;
        run(20, -1, "lockout");

        // Reset asserted between edges at n=9, after a slip at n=9.
        do_reset("b");
        fill_pattern(12);
        al[9] = 1'b1;
        run(12, 9, "midrst");

        // Four slips six cycles apart: offset wraps back to 0.
        do_reset("c");
        fill_pattern(30);
        al[3]  = 1'b1;
        al[9]  = 1'b1;
        al[15] = 1'b1;
        al[21] = 1'b1;
        run(30, -1, "wrap");

        // ALIGNWD held high for many cycles gives a single slip.
        do_reset("d");
        fill_pattern(24);
        for (int n = 4; n < 18; n++) al[n] = 1'b1;
        run(24, -1, "held");

        // Random data and random slip requests.
        do_reset("e");
        fill_random(200);
        run(200, -1, "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
